// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: single-register read/write sequencer in front of i2c_master.
// Steps the master one byte per ack through write or restart-read framing.
module i2c_reg_seq #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic [1:0] resp_err,
    output logic       m_enable,
    output logic       m_rw,
    output logic [6:0] m_address,
    output logic [7:0] m_txdata,
    output logic       m_restart,
    input  logic       m_ready,
    input  logic       m_ack,
    input  logic       m_nack,
    input  logic [7:0] m_rxdata
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_W,
        REG,
        WDATA,
        ADDR_R,
        RDATA,
        STOP,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_write;
    logic [7:0]    wdata;
    logic [1:0]    err;
    logic          accept;
    logic          active;
    logic          byte_phase;
    logic          tmo;

    assign accept = (state == IDLE) && req_valid && req_ready;

    assign active = (state != IDLE) && (state != DONE);

    assign byte_phase = (state == ADDR_W) || (state == REG) ||
                        (state == WDATA)  || (state == ADDR_R) ||
                        (state == RDATA);

    assign tmo = active && (cnt == TLAST);

    // Watchdog: counts cycles since the last master event while active.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept || m_ack || m_nack || !active) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Transaction FSM; all host and master-facing outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 8'h00;
            resp_err   <= 2'd0;
            m_enable   <= 1'b0;
            m_rw       <= 1'b0;
            m_address  <= 7'h00;
            m_txdata   <= 8'h00;
            m_restart  <= 1'b0;
            is_write   <= 1'b0;
            wdata      <= 8'h00;
            err        <= 2'd0;
        end else begin
            resp_valid <= 1'b0;
            m_restart  <= 1'b0;
            if (tmo) begin
                // Give up without waiting for the bus to be released.
                m_enable   <= 1'b0;
                err        <= 2'd2;
                resp_err   <= 2'd2;
                resp_valid <= 1'b1;
                state      <= DONE;
            end else if (m_nack && byte_phase) begin
                // NACK beats a simultaneous ACK; let the master STOP.
                m_enable <= 1'b0;
                err      <= 2'd1;
                state    <= STOP;
            end else begin
                unique case (state)
                    IDLE: begin
                        req_ready <= !accept;
                        if (accept) begin
                            is_write  <= req_write;
                            wdata     <= req_wdata;
                            err       <= 2'd0;
                            m_address <= req_dev;
                            m_rw      <= 1'b0;
                            m_txdata  <= req_reg;
                            m_enable  <= 1'b1;
                            state     <= ADDR_W;
                        end
                    end
                    ADDR_W: begin
                        if (m_ack) begin
                            // Master fetches the byte after reg on reg's ack.
                            if (is_write) begin
                                m_txdata <= wdata;
                            end
                            state <= REG;
                        end
                    end
                    REG: begin
                        if (m_ack) begin
                            if (is_write) begin
                                m_enable <= 1'b0;
                                state    <= WDATA;
                            end else begin
                                m_rw      <= 1'b1;
                                m_restart <= 1'b1;
                                state     <= ADDR_R;
                            end
                        end
                    end
                    WDATA: begin
                        if (m_ack) begin
                            state <= STOP;
                        end
                    end
                    ADDR_R: begin
                        if (m_ack) begin
                            // Disabled read: master takes one byte, NACKs it.
                            m_enable <= 1'b0;
                            state    <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (m_ack) begin
                            resp_rdata <= m_rxdata;
                            state      <= STOP;
                        end
                    end
                    STOP: begin
                        if (m_ready) begin
                            resp_valid <= 1'b1;
                            resp_err   <= err;
                            state      <= DONE;
                        end
                    end
                    DONE: begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: directed and random register traffic through a
// behavioural master/slave, checked against a register-file model.
module tb_i2c_reg_seq;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_dev = 7'h00;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic [1:0] resp_err;
    logic       m_enable;
    logic       m_rw;
    logic [6:0] m_address;
    logic [7:0] m_txdata;
    logic       m_restart;
    logic       m_ready = 1'b1;
    logic       m_ack = 1'b0;
    logic       m_nack = 1'b0;
    logic [7:0] m_rxdata = 8'h00;

    i2c_reg_seq #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_dev    (req_dev),
        .req_reg    (req_reg),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m_enable   (m_enable),
        .m_rw       (m_rw),
        .m_address  (m_address),
        .m_txdata   (m_txdata),
        .m_restart  (m_restart),
        .m_ready    (m_ready),
        .m_ack      (m_ack),
        .m_nack     (m_nack),
        .m_rxdata   (m_rxdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Edge counter and accept / pulse monitors.
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int rv_cnt = 0;
    int rs_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (resp_valid) rv_cnt <= rv_cnt + 1;
        if (m_restart) rs_cnt <= rs_cnt + 1;
    end

    // Bus environment: slave memory, bus byte log, master behaviour.
    logic [7:0] smem    [0:32767];
    logic [7:0] ref_mem [0:32767];
    logic [7:0] ref_rd = 8'h00;
    logic [7:0] bus_q[$];
    logic [6:0] absent = 7'h52;
    bit         stall = 1'b0;
    int         ack_cnt = 0;
    int         rdy_cyc = 0;

    task automatic finish_stop();
        repeat ($urandom_range(2, 4)) begin
            @(negedge clk);
            if (reset) return;
        end
        m_ready = 1'b1;
        rdy_cyc = cyc;
    endtask

    task automatic run_txn();
        logic [7:0] cur;
        logic [7:0] nxt;
        logic [7:0] ptr;
        logic [6:0] dv;
        bit         is_addr;
        bit         en_at;
        int         idx;
        m_ready = 1'b0;
        cur = {m_address, m_rw};
        dv = m_address;
        bus_q.push_back(cur);
        is_addr = 1'b1;
        idx = 0;
        ptr = 8'h00;
        forever begin
            if (stall) begin
                for (int i = 0; i < 200 && m_enable; i++) begin
                    @(negedge clk);
                    if (reset) return;
                end
                finish_stop();
                return;
            end
            repeat ($urandom_range(2, 5)) begin
                @(negedge clk);
                if (reset) return;
            end
            if (is_addr && cur[7:1] == absent) begin
                m_nack = 1'b1;
                @(negedge clk);
                m_nack = 1'b0;
                if (reset) return;
                check("nack_en_drop", m_enable, 0);
                finish_stop();
                return;
            end
            en_at = m_enable;
            nxt = m_txdata;
            m_ack = 1'b1;
            @(negedge clk);
            m_ack = 1'b0;
            ack_cnt++;
            if (reset) return;
            if (!is_addr) begin
                if (idx == 0) ptr = cur;
                else begin
                    smem[{dv, ptr}] = cur;
                    ptr = ptr + 8'd1;
                end
                idx++;
            end
            if (m_restart) begin
                check("restart_rw", m_rw, 1);
                cur = {m_address, m_rw};
                dv = m_address;
                bus_q.push_back(cur);
                is_addr = 1'b1;
            end else if (is_addr && cur[0]) begin
                repeat ($urandom_range(2, 5)) begin
                    @(negedge clk);
                    if (reset) return;
                end
                m_rxdata = smem[{dv, ptr}];
                m_ack = 1'b1;
                @(negedge clk);
                m_ack = 1'b0;
                ack_cnt++;
                if (reset) return;
                finish_stop();
                return;
            end else if (!en_at) begin
                finish_stop();
                return;
            end else begin
                cur = nxt;
                bus_q.push_back(cur);
                is_addr = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ready = 1'b1;
                m_ack = 1'b0;
                m_nack = 1'b0;
            end else if (m_enable && m_ready) begin
                run_txn();
                if (reset) begin
                    m_ready = 1'b1;
                    m_ack = 1'b0;
                    m_nack = 1'b0;
                end
            end
        end
    end

    // Host side: issue one request, wait for its response.
    task automatic do_req(input bit wr, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd,
                          output int a_cyc, output int r_cyc);
        int a0;
        bit got;
        a0 = acc_cnt;
        req_valid = 1'b1;
        req_write = wr;
        req_dev = dev;
        req_reg = rg;
        req_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (acc_cnt != a0);
        end
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_dev = 7'($urandom);
        req_reg = 8'($urandom);
        req_wdata = 8'($urandom);
        check("accept", got, 1);
        if (got) check("en_latency", m_enable, 1);
        a_cyc = acc_cyc;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        check("resp_seen", got, 1);
        r_cyc = cyc;
    endtask

    // One request with reference prediction and bus-log comparison.
    task automatic txn(input bit wr, input logic [6:0] dev,
                       input logic [7:0] rg, input logic [7:0] wd,
                       output int a_cyc, output int r_cyc);
        int         ak0;
        int         rs0;
        int         e_acks;
        int         e_rs;
        logic [1:0] e_err;
        logic [7:0] exp_q[$];
        logic [7:0] aw;
        logic [7:0] ar;
        bus_q.delete();
        ak0 = ack_cnt;
        rs0 = rs_cnt;
        aw = {dev, 1'b0};
        ar = {dev, 1'b1};
        exp_q.push_back(aw);
        do_req(wr, dev, rg, wd, a_cyc, r_cyc);
        if (dev == absent) begin
            e_err = 2'd1;
            e_acks = 0;
            e_rs = 0;
        end else if (wr) begin
            e_err = 2'd0;
            e_acks = 3;
            e_rs = 0;
            ref_mem[{dev, rg}] = wd;
            exp_q.push_back(rg);
            exp_q.push_back(wd);
        end else begin
            e_err = 2'd0;
            e_acks = 4;
            e_rs = 1;
            ref_rd = ref_mem[{dev, rg}];
            exp_q.push_back(rg);
            exp_q.push_back(ar);
        end
        check("err", resp_err, e_err);
        check("rdata", resp_rdata, ref_rd);
        check("ready_to_resp", r_cyc - rdy_cyc, 1);
        check("bus_len", bus_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
            check($sformatf("bus_byte%0d", i), bus_q[i], exp_q[i]);
        check("ack_count", ack_cnt - ak0, e_acks);
        check("restart_cycles", rs_cnt - rs0, e_rs);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, req_ready, 0);
        check({pfx, "_resp_valid"}, resp_valid, 0);
        check({pfx, "_resp_rdata"}, resp_rdata, 0);
        check({pfx, "_resp_err"}, resp_err, 0);
        check({pfx, "_m_enable"}, m_enable, 0);
        check({pfx, "_m_rw"}, m_rw, 0);
        check({pfx, "_m_address"}, m_address, 0);
        check({pfx, "_m_txdata"}, m_txdata, 0);
        check({pfx, "_m_restart"}, m_restart, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  a_cyc;
        int  r_cyc;
        int  a0;
        int  rs0;
        int  rv0;
        bit  got;
        bit  wr;
        logic [6:0] dev;
        logic [6:0] devs [4];

        for (int i = 0; i < 32768; i++) begin
            smem[i] = 8'($urandom);
            ref_mem[i] = smem[i];
        end
        smem[{7'h51, 8'h20}] = 8'hBB;
        ref_mem[{7'h51, 8'h20}] = 8'hBB;

        // Reset values, then ready one edge after release.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Directed write, read, absent slave.
        txn(1'b1, 7'h50, 8'h10, 8'hA5, a_cyc, r_cyc);
        txn(1'b0, 7'h51, 8'h20, 8'h00, a_cyc, r_cyc);
        check("read_bb", resp_rdata, 8'hBB);
        txn(1'b0, 7'h52, 8'h20, 8'h00, a_cyc, r_cyc);
        check("absent_rdata_kept", resp_rdata, 8'hBB);

        // Timeout: master never reports an event after accept.
        repeat (2) @(negedge clk);
        stall = 1'b1;
        do_req(1'b1, 7'h50, 8'h30, 8'h77, a_cyc, r_cyc);
        check("tmo_err", resp_err, 2);
        check("tmo_latency", r_cyc - a_cyc, TMO);
        check("tmo_enable", m_enable, 0);
        check("tmo_rdata_kept", resp_rdata, ref_rd);
        stall = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = m_ready;
        end
        check("tmo_bus_release", got, 1);

        // Reset while waiting for the read address ack.
        a0 = acc_cnt;
        rs0 = rs_cnt;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_dev = 7'h51;
        req_reg = 8'h20;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (acc_cnt != a0);
        end
        req_valid = 1'b0;
        check("mid_accept", got, 1);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (rs_cnt != rs0);
        end
        check("mid_reach_addr_r", got, 1);
        reset = 1'b1;
        rv0 = rv_cnt;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        ref_rd = 8'h00;
        @(negedge clk);
        check("midrst_ready", req_ready, 1);
        repeat (20) @(negedge clk);
        check("midrst_no_resp", rv_cnt - rv0, 0);
        txn(1'b1, 7'h50, 8'h40, 8'h5C, a_cyc, r_cyc);

        // Back-to-back write then read of the same register.
        repeat (2) @(negedge clk);
        txn(1'b1, 7'h50, 8'h01, 8'h11, a_cyc, r_cyc);
        rv0 = r_cyc;
        txn(1'b0, 7'h50, 8'h01, 8'h00, a_cyc, r_cyc);
        check("b2b_rdata", resp_rdata, 8'h11);
        check("b2b_gap", a_cyc - rv0, 2);

        // Random traffic.
        devs[0] = 7'h50;
        devs[1] = 7'h51;
        devs[2] = 7'h33;
        devs[3] = 7'h52;
        for (int n = 0; n < 30; n++) begin
            wr = 1'($urandom);
            dev = ($urandom_range(0, 7) == 0) ? devs[3]
                                               : devs[$urandom_range(0, 2)];
            repeat ($urandom_range(0, 3)) @(negedge clk);
            txn(wr, dev, 8'($urandom_range(0, 7)), 8'($urandom),
                a_cyc, r_cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_reg_seq.md
# i2c_reg_seq

Register-access sequencer sitting directly upstream of `i2c_master`. It accepts single-register read/write requests from a host and drives the master's `enable/rw/address/txdata/restart` inputs byte by byte, consuming `ready/ack/nack/rxdata`. A write is START, addr+W, reg, data, STOP. A read is START, addr+W, reg, repeated START, addr+R, one data byte with master NACK, STOP.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096 — max `clk` cycles between master events before abort; ≥ 2.

Ports:
- `clk` in 1 — system clock, same clock as `i2c_master`.
- `reset` in 1 — synchronous, active-high reset.
- `req_valid` in 1 — host request present.
- `req_ready` out 1 — block can accept a request.
- `req_write` in 1 — 1 = write, 0 = read.
- `req_dev` in 7 — 7-bit slave address.
- `req_reg` in 8 — register index.
- `req_wdata` in 8 — write data.
- `resp_valid` out 1 — one-cycle completion pulse.
- `resp_rdata` out 8 — read data, valid with `resp_valid` and `resp_err`=0 on a read.
- `resp_err` out 2 — 0 ok, 1 NACK, 2 timeout.
- `m_enable` out 1 — to master `enable`.
- `m_rw` out 1 — to master `rw`.
- `m_address` out 7 — to master `address`.
- `m_txdata` out 8 — to master `txdata`.
- `m_restart` out 1 — to master `restart`, one-cycle pulse.
- `m_ready` in 1 — master idle, bus released.
- `m_ack` in 1 — one-cycle pulse per byte ACKed by the slave, or per read byte received.
- `m_nack` in 1 — one-cycle pulse, slave NACKed.
- `m_rxdata` in 8 — master receive byte, valid on the read-phase data `m_ack`.

## Operation
- Master contract: the master loads the next transmit byte from `m_txdata` on the `m_ack` of the preceding byte. Dropping `m_enable` makes the master finish the byte in flight, then STOP, then raise `m_ready`. While enabled after the last transmitted byte in the read direction, the master receives one byte, NACKs it, then STOPs.
- `req_ready` = 1 only in IDLE. Handshake fires when `req_valid && req_ready`. Request fields are registered at that edge. Host inputs are ignored outside IDLE.
- States and transitions:
  - IDLE: on accept, drive `m_address`=req_dev, `m_rw`=0, `m_txdata`=req_reg, `m_enable`=1 → ADDR_W.
  - ADDR_W: on `m_ack` → REG. For a write, `m_txdata`←wdata on the next cycle.
  - REG: on `m_ack`:
    - write: `m_enable`←0 → WDATA.
    - read: `m_rw`←1, pulse `m_restart` one cycle → ADDR_R.
  - WDATA: on `m_ack` → STOP.
  - ADDR_R: on `m_ack`, `m_enable`←0 → RDATA.
  - RDATA: on `m_ack`, capture `m_rxdata` → STOP.
  - STOP: wait for `m_ready`=1 → DONE.
  - DONE: `resp_valid`=1 for one cycle → IDLE.
- `m_nack` in any active state: `m_enable`←0, err←1 → STOP. If `m_nack` and `m_ack` occur in the same cycle, NACK wins.
- Timeout counter: cleared on accept and on every `m_ack`/`m_nack`. Increments in ADDR_W…STOP. At `TIMEOUT_CYCLES`-1: `m_enable`←0, err←2 → DONE without waiting for `m_ready`.
- `resp_rdata` holds its last captured value; it changes only on a read-phase capture.

## Timing
- Every output is registered.
- Reset values: `req_ready`=0 during reset and 1 on the first cycle after reset; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `m_enable`=0, `m_rw`=0, `m_address`=0, `m_txdata`=0, `m_restart`=0. State = IDLE, counter = 0.
- Reset mid-transaction: `m_enable` drops on the next edge, no response is issued, and the block is in IDLE the cycle after reset deasserts.
- Accept → `m_enable`=1: 1 cycle.
- Final `m_ack` or `m_nack` → STOP entry: 1 cycle. `m_ready` seen in STOP → `resp_valid`: 1 cycle.
- `req_ready` returns 1 the cycle after `resp_valid`. Minimum gap between back-to-back requests is 1 idle cycle.
- `m_restart` is high exactly 1 cycle, coincident with `m_rw` becoming 1.

## Test plan
- Write: dev 0x50, reg 0x10, wdata 0xA5, slave ACKs all bytes → `m_txdata` sequence 0x10 then 0xA5. Three `m_ack` pulses. `resp_valid` with err 0. `m_restart` never asserted.
- Read: dev 0x51, reg 0x20, slave returns 0xBB → one `m_restart` pulse, `m_rw` goes 0→1. `resp_rdata`=0xBB, err 0.
- Absent slave: dev 0x52, slave NACKs the address → `m_enable` low 1 cycle after the NACK. After `m_ready`, `resp_valid` with err 1. `resp_rdata` unchanged.
- Timeout: `TIMEOUT_CYCLES`=16, master stalls with no ack → `resp_valid` with err 2 exactly 16 cycles after the last event. `m_enable`=0.
- Reset mid-read (asserted in ADDR_R) → all outputs at reset values, no `resp_valid`. A following write to dev 0x50 completes with err 0.
- Back-to-back: write 0x50/0x01/0x11 immediately followed by read 0x50/0x01 → read returns 0x11. Exactly one idle cycle between `resp_valid` and the next accept.
